// File: rtl/pipe_hazard_ctrl_if.sv
// Control bundle between the pipeline datapath and the hazard sequencer.
// The datapath side is the master; the sequencer is the slave.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             ex_wreg;
    logic             ex_m2reg;
    logic [4:0]       ex_rn;
    logic             id_br_taken;
    logic             id_jump;
    logic             ex_md_start;
    logic             halt_req;
    logic             step_req;
    logic             resume_req;
    logic             stall;
    logic [1:0]       pcsource;
    logic             flush_id;
    logic             bubble_ex;
    logic             hold_ex;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, ex_wreg, ex_m2reg, ex_rn,
               id_br_taken, id_jump, ex_md_start, halt_req, step_req, resume_req,
        input  stall, pcsource, flush_id, bubble_ex, hold_ex, halted, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, ex_wreg, ex_m2reg, ex_rn,
               id_br_taken, id_jump, ex_md_start, halt_req, step_req, resume_req,
        output stall, pcsource, flush_id, bubble_ex, hold_ex, halted, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/redirect sequencer for the 5-stage pipeline: load-use stalls, branch/jump
// redirects, mul/div front-end hold and halt/single-step debug control.
module pipe_hazard_ctrl #(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  clr,
    pipe_hazard_ctrl_if.slave     bus
);
    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_MDBUSY = 2'd1;
    localparam logic [1:0] ST_HALT   = 2'd2;
    localparam logic [1:0] ST_STEP   = 2'd3;

    localparam logic [1:0] PC_PC4 = 2'b00;
    localparam logic [1:0] PC_BPC = 2'b01;
    localparam logic [1:0] PC_JPC = 2'b10;

    // Counter is loaded with MD_LAT-2 so the front end is held MD_LAT-1 cycles in total.
    localparam logic [3:0] MD_INIT = 4'(MD_LAT - 2);

    logic [1:0]       state_reg, state_next;
    logic [3:0]       md_cnt_reg, md_cnt_next;
    logic [CNT_W-1:0] stall_cnt_reg;

    logic [1:0] src_hit;
    logic       load_use;
    logic       stall_c, flush_c, bubble_c, hold_c, halted_c;
    logic [1:0] pcsource_c;

    // Operand 0 is rs, operand 1 is rt.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            logic [4:0] src_reg_num;
            logic       src_used;
            assign src_reg_num = (gi == 0) ? bus.id_rs : bus.id_rt;
            assign src_used    = (gi == 0) ? bus.id_use_rs : bus.id_use_rt;
            assign src_hit[gi] = src_used & (bus.ex_rn == src_reg_num);
        end
    endgenerate

    assign load_use = bus.ex_wreg & bus.ex_m2reg & (bus.ex_rn != 5'd0) & (|src_hit);

    always_comb begin
        stall_c    = 1'b0;
        flush_c    = 1'b0;
        bubble_c   = 1'b0;
        hold_c     = 1'b0;
        halted_c   = 1'b0;
        pcsource_c = PC_PC4;
        if (!clr) begin
            case (state_reg)
                ST_RUN, ST_STEP: begin
                    // A pending redirect waits out the load-use bubble and is taken next cycle.
                    if (load_use) begin
                        stall_c  = 1'b1;
                        bubble_c = 1'b1;
                    end else if (bus.id_jump) begin
                        pcsource_c = PC_JPC;
                        flush_c    = 1'b1;
                    end else if (bus.id_br_taken) begin
                        pcsource_c = PC_BPC;
                        flush_c    = 1'b1;
                    end
                end
                ST_MDBUSY: begin
                    stall_c = 1'b1;
                    hold_c  = 1'b1;
                end
                default: begin
                    stall_c  = 1'b1;
                    halted_c = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        state_next  = state_reg;
        md_cnt_next = md_cnt_reg;
        case (state_reg)
            ST_RUN: begin
                if (bus.ex_md_start) begin
                    state_next  = ST_MDBUSY;
                    md_cnt_next = MD_INIT;
                end else if (bus.halt_req) begin
                    state_next = ST_HALT;
                end
            end
            ST_MDBUSY: begin
                if (md_cnt_reg == 4'd0) begin
                    state_next = ST_RUN;
                end else begin
                    md_cnt_next = md_cnt_reg - 4'd1;
                end
            end
            ST_HALT: begin
                if (bus.resume_req) begin
                    state_next = ST_RUN;
                end else if (bus.step_req) begin
                    state_next = ST_STEP;
                end
            end
            default: begin
                if (bus.ex_md_start) begin
                    state_next  = ST_MDBUSY;
                    md_cnt_next = MD_INIT;
                end else begin
                    state_next = ST_HALT;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg     <= ST_RUN;
            md_cnt_reg    <= 4'd0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            md_cnt_reg <= md_cnt_next;
            if (stall_c && (stall_cnt_reg != {CNT_W{1'b1}})) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
        end
    end

    assign bus.stall     = stall_c;
    assign bus.pcsource  = pcsource_c;
    assign bus.flush_id  = flush_c;
    assign bus.bubble_ex = bubble_c;
    assign bus.hold_ex   = hold_c;
    assign bus.halted    = halted_c;
    assign bus.stall_cnt = clr ? '0 : stall_cnt_reg;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a cycle-level reference model checked every cycle,
// plus hand-computed literal expectations at key points of each scenario.
module tb_pipe_hazard_ctrl;
    localparam int MD_LAT = 4;
    localparam int CNT_W  = 4;

    logic clk = 1'b0;
    logic clr;
    int   tests  = 0;
    int   failed = 0;
    bit   chk_en = 1'b0;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 run, 1 mul/div busy, 2 halted, 3 single step.
    int m_mode      = 0;
    int m_busy_left = 0;
    int m_cnt       = 0;

    // Packed as {stall, pcsource[1:0], flush_id, bubble_ex, hold_ex, halted}.
    function automatic logic [6:0] model_out();
        logic lu;
        logic [6:0] o;
        o = 7'b0;
        lu = bus.ex_wreg && bus.ex_m2reg && bus.ex_rn != 0 &&
             ((bus.id_use_rs && bus.ex_rn == bus.id_rs) || (bus.id_use_rt && bus.ex_rn == bus.id_rt));
        if (clr) return o;
        if (m_mode == 1) o = 7'b1000010;
        else if (m_mode == 2) o = 7'b1000001;
        else if (lu) o = 7'b1000100;
        else if (bus.id_jump) o = 7'b0101000;
        else if (bus.id_br_taken) o = 7'b0011000;
        return o;
    endfunction

    always @(posedge clk) begin
        logic [6:0] o;
        o = model_out();
        if (clr) begin
            m_mode = 0; m_busy_left = 0; m_cnt = 0;
        end else begin
            if (o[6] && m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
            case (m_mode)
                0, 3: begin
                    if (bus.ex_md_start) begin m_mode = 1; m_busy_left = MD_LAT - 1; end
                    else if (m_mode == 3) m_mode = 2;
                    else if (bus.halt_req) m_mode = 2;
                end
                1: begin
                    m_busy_left = m_busy_left - 1;
                    if (m_busy_left == 0) m_mode = 0;
                end
                default: begin
                    if (bus.resume_req) m_mode = 0;
                    else if (bus.step_req) m_mode = 3;
                end
            endcase
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [6:0] e;
            e = model_out();
            check("mdl_stall",     int'(bus.stall),     int'(e[6]));
            check("mdl_pcsource",  int'(bus.pcsource),  int'(e[5:4]));
            check("mdl_flush_id",  int'(bus.flush_id),  int'(e[3]));
            check("mdl_bubble_ex", int'(bus.bubble_ex), int'(e[2]));
            check("mdl_hold_ex",   int'(bus.hold_ex),   int'(e[1]));
            check("mdl_halted",    int'(bus.halted),    int'(e[0]));
            check("mdl_stall_cnt", int'(bus.stall_cnt), clr ? 0 : m_cnt);
        end
    end

    task automatic idle();
        bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_use_rs = 1'b0; bus.id_use_rt = 1'b0;
        bus.ex_wreg = 1'b0; bus.ex_m2reg = 1'b0; bus.ex_rn = 5'd0;
        bus.id_br_taken = 1'b0; bus.id_jump = 1'b0; bus.ex_md_start = 1'b0;
        bus.halt_req = 1'b0; bus.step_req = 1'b0; bus.resume_req = 1'b0;
    endtask

    task automatic randin();
        bus.id_rs = 5'($urandom); bus.id_rt = 5'($urandom);
        bus.id_use_rs = 1'($urandom); bus.id_use_rt = 1'($urandom);
        bus.ex_wreg = 1'($urandom); bus.ex_m2reg = 1'($urandom); bus.ex_rn = 5'($urandom);
        bus.id_br_taken = 1'($urandom); bus.id_jump = 1'($urandom);
        bus.ex_md_start = 1'($urandom); bus.halt_req = 1'($urandom);
        bus.step_req = 1'($urandom); bus.resume_req = 1'($urandom);
    endtask

    task automatic lu_rs(input logic [4:0] rn);
        bus.ex_wreg = 1'b1; bus.ex_m2reg = 1'b1; bus.ex_rn = rn;
        bus.id_rs = 5'd5; bus.id_use_rs = 1'b1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        clr = 1'b1;
        randin();
        chk_en = 1'b1;
        // Reset with random inputs.
        for (int i = 0; i < 2; i++) begin
            mid();
            check("rst_stall", int'(bus.stall), 0);
            check("rst_pcsource", int'(bus.pcsource), 0);
            check("rst_halted", int'(bus.halted), 0);
            check("rst_stall_cnt", int'(bus.stall_cnt), 0);
            cyc();
            randin();
        end
        clr = 1'b0;
        idle();
        mid();
        check("post_rst_stall", int'(bus.stall), 0);
        check("post_rst_cnt", int'(bus.stall_cnt), 0);
        cyc();

        // Load-use on rs.
        lu_rs(5'd5);
        mid();
        check("lu_stall", int'(bus.stall), 1);
        check("lu_bubble", int'(bus.bubble_ex), 1);
        check("lu_flush", int'(bus.flush_id), 0);
        cyc();
        idle();
        mid();
        check("lu_cnt", int'(bus.stall_cnt), 1);
        check("lu_released", int'(bus.stall), 0);
        cyc();
        lu_rs(5'd0);
        mid();
        check("lu_r0_stall", int'(bus.stall), 0);
        cyc();
        // Load-use on rt, then rt match without use flag.
        idle();
        bus.ex_wreg = 1'b1; bus.ex_m2reg = 1'b1; bus.ex_rn = 5'd7;
        bus.id_rt = 5'd7; bus.id_use_rt = 1'b1;
        mid();
        check("lu_rt_stall", int'(bus.stall), 1);
        cyc();
        bus.id_use_rt = 1'b0;
        mid();
        check("lu_rt_unused", int'(bus.stall), 0);
        cyc();
        idle();

        // Branch and jump redirects.
        bus.id_br_taken = 1'b1;
        mid();
        check("br_pcsource", int'(bus.pcsource), 1);
        check("br_flush", int'(bus.flush_id), 1);
        cyc();
        bus.id_jump = 1'b1;
        mid();
        check("jmp_pcsource", int'(bus.pcsource), 2);
        cyc();
        idle();
        lu_rs(5'd5);
        bus.id_br_taken = 1'b1;
        mid();
        check("br_lu_pcsource", int'(bus.pcsource), 0);
        check("br_lu_flush", int'(bus.flush_id), 0);
        cyc();
        idle();
        bus.id_br_taken = 1'b1;
        mid();
        check("br_after_lu", int'(bus.pcsource), 1);
        cyc();
        idle();

        // Mul/div hold; halt_req during busy is ignored.
        bus.ex_md_start = 1'b1;
        mid();
        check("md_start_stall", int'(bus.stall), 0);
        cyc();
        bus.ex_md_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.halt_req = (i == 1);
            mid();
            check("md_busy_stall", int'(bus.stall), 1);
            check("md_busy_hold", int'(bus.hold_ex), 1);
            cyc();
        end
        idle();
        mid();
        check("md_done_stall", int'(bus.stall), 0);
        check("md_done_halted", int'(bus.halted), 0);
        cyc();

        // Reset in the second busy cycle.
        bus.ex_md_start = 1'b1;
        cyc();
        bus.ex_md_start = 1'b0;
        cyc();
        clr = 1'b1;
        mid();
        check("md_clr_stall", int'(bus.stall), 0);
        check("md_clr_hold", int'(bus.hold_ex), 0);
        cyc();
        clr = 1'b0;
        mid();
        check("md_clr_after", int'(bus.hold_ex), 0);
        check("md_clr_cnt", int'(bus.stall_cnt), 0);
        cyc();

        // Halt, single step, step+resume.
        bus.halt_req = 1'b1;
        mid();
        check("halt_req_cycle", int'(bus.halted), 0);
        cyc();
        bus.halt_req = 1'b0;
        mid();
        check("halt_halted", int'(bus.halted), 1);
        check("halt_stall", int'(bus.stall), 1);
        cyc();
        bus.step_req = 1'b1;
        mid();
        cyc();
        bus.step_req = 1'b0;
        mid();
        check("step_stall", int'(bus.stall), 0);
        check("step_halted", int'(bus.halted), 0);
        cyc();
        mid();
        check("step_rehalt", int'(bus.halted), 1);
        bus.step_req = 1'b1;
        bus.resume_req = 1'b1;
        cyc();
        idle();
        mid();
        check("resume_halted", int'(bus.halted), 0);
        cyc();
        mid();
        check("resume_stays_run", int'(bus.stall), 0);

        // Step that starts a mul/div returns to RUN.
        bus.halt_req = 1'b1;
        cyc();
        bus.halt_req = 1'b0;
        bus.step_req = 1'b1;
        cyc();
        bus.step_req = 1'b0;
        bus.ex_md_start = 1'b1;
        cyc();
        bus.ex_md_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mid();
            check("step_md_hold", int'(bus.hold_ex), 1);
            cyc();
        end
        mid();
        check("step_md_run", int'(bus.halted), 0);
        check("step_md_stall", int'(bus.stall), 0);
        cyc();

        // Saturating stall counter across a long halt.
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        bus.halt_req = 1'b1;
        cyc();
        bus.halt_req = 1'b0;
        repeat ((1 << CNT_W) + 3) cyc();
        mid();
        check("cnt_sat", int'(bus.stall_cnt), 15);
        repeat (3) cyc();
        mid();
        check("cnt_sat_hold", int'(bus.stall_cnt), 15);
        bus.resume_req = 1'b1;
        cyc();
        idle();
        mid();
        check("cnt_resume", int'(bus.halted), 0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
